// File: rtl/regfile_march_bist.sv
// DEPTH x WIDTH flop register file with a March C- self-test controller.
// Functional 1W/1R access when idle; BIST owns the array while running.
module regfile_march_bist #(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 4,
  parameter int AW         = $clog2(DEPTH),
  parameter int FAULT_ADDR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] d_in,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] d_out,
  input  logic             bist_start,
  input  logic             fault_inj,
  output logic             bist_busy,
  output logic             bist_done,
  output logic             pass,
  output logic [AW-1:0]    fail_addr,
  output logic [WIDTH-1:0] fail_syndrome
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] EL_W0     = 3'd0;
  localparam logic [2:0] EL_R0W1   = 3'd1;
  localparam logic [2:0] EL_R1W0   = 3'd2;
  localparam logic [2:0] EL_DR0W1  = 3'd3;
  localparam logic [2:0] EL_DR1W0  = 3'd4;
  localparam logic [2:0] EL_R0     = 3'd5;

  localparam logic [AW-1:0]    ADDR_LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0]    ADDR_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0]    ADDR_FAULT = AW'(FAULT_ADDR);
  localparam logic [WIDTH-1:0] ZEROS      = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES       = {WIDTH{1'b1}};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [1:0]       state_r;
  logic [2:0]       elem_r, elem_nxt_s;
  logic [AW-1:0]    addr_r, addr_nxt_s;
  logic             phase_r, phase_nxt_s;
  logic             err_r;
  logic             bist_we_s, cmp_en_s, adv_s, down_s, addr_end_s, last_op_s, mismatch_s;
  logic [WIDTH-1:0] bist_wdata_s, exp_s, rd_view_s;

  // Array word as seen through the stuck-at-0 injection on bit 0 of FAULT_ADDR.
  function automatic logic [WIDTH-1:0] inj_view(input logic [WIDTH-1:0] word,
                                                input logic [AW-1:0] addr, input logic inj);
    logic [WIDTH-1:0] v;
    v = word;
    if (inj && (addr == ADDR_FAULT)) v[0] = 1'b0;
    else v[0] = word[0];
    return v;
  endfunction

  assign rd_view_s  = inj_view(mem_r[addr_r], addr_r, fault_inj);
  assign mismatch_s = cmp_en_s && (rd_view_s != exp_s);
  assign d_out      = (state_r == ST_RUN) ? ZEROS : inj_view(mem_r[rd_addr], rd_addr, fault_inj);

  // March C- op decode and sequencing: pair elements read in phase 0, write in phase 1.
  always_comb begin
    bist_we_s    = 1'b0;
    bist_wdata_s = ZEROS;
    cmp_en_s     = 1'b0;
    exp_s        = ZEROS;
    adv_s        = 1'b0;
    elem_nxt_s   = elem_r;
    addr_nxt_s   = addr_r;
    phase_nxt_s  = phase_r;
    last_op_s    = 1'b0;
    down_s       = (elem_r == EL_DR0W1) || (elem_r == EL_DR1W0);
    addr_end_s   = down_s ? (addr_r == ADDR_ZERO) : (addr_r == ADDR_LAST);
    case (elem_r)
      EL_W0: begin
        bist_we_s = 1'b1;
        adv_s     = 1'b1;
      end
      EL_R0W1, EL_R1W0, EL_DR0W1, EL_DR1W0: begin
        if (!phase_r) begin
          cmp_en_s = 1'b1;
          exp_s    = ((elem_r == EL_R1W0) || (elem_r == EL_DR1W0)) ? ONES : ZEROS;
        end else begin
          bist_we_s    = 1'b1;
          bist_wdata_s = ((elem_r == EL_R0W1) || (elem_r == EL_DR0W1)) ? ONES : ZEROS;
          adv_s        = 1'b1;
        end
      end
      EL_R0: begin
        cmp_en_s = 1'b1;
        adv_s    = 1'b1;
      end
      default: begin
        adv_s = 1'b1;
      end
    endcase
    if (adv_s) begin
      phase_nxt_s = 1'b0;
      if (addr_end_s) begin
        elem_nxt_s = elem_r + 3'd1;
        addr_nxt_s = ((elem_r == EL_R1W0) || (elem_r == EL_DR0W1)) ? ADDR_LAST : ADDR_ZERO;
        last_op_s  = (elem_r == EL_R0);
      end else begin
        addr_nxt_s = down_s ? (addr_r - AW'(1)) : (addr_r + AW'(1));
      end
    end else begin
      phase_nxt_s = 1'b1;
    end
  end

  // Storage: BIST owns the write port while running, functional writes otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= ZEROS;
    end else if (state_r == ST_RUN) begin
      if (bist_we_s) mem_r[addr_r] <= bist_wdata_s;
    end else if (wr_en) begin
      mem_r[wr_addr] <= d_in;
    end
  end

  // Controller FSM and result capture; only the first mismatch is recorded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      elem_r        <= EL_W0;
      addr_r        <= ADDR_ZERO;
      phase_r       <= 1'b0;
      err_r         <= 1'b0;
      bist_busy     <= 1'b0;
      bist_done     <= 1'b0;
      pass          <= 1'b0;
      fail_addr     <= ADDR_ZERO;
      fail_syndrome <= ZEROS;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (bist_start) begin
            state_r       <= ST_RUN;
            elem_r        <= EL_W0;
            addr_r        <= ADDR_ZERO;
            phase_r       <= 1'b0;
            err_r         <= 1'b0;
            bist_busy     <= 1'b1;
            bist_done     <= 1'b0;
            pass          <= 1'b0;
            fail_addr     <= ADDR_ZERO;
            fail_syndrome <= ZEROS;
          end
        end
        ST_RUN: begin
          elem_r  <= elem_nxt_s;
          addr_r  <= addr_nxt_s;
          phase_r <= phase_nxt_s;
          if (mismatch_s && !err_r) begin
            err_r         <= 1'b1;
            fail_addr     <= addr_r;
            fail_syndrome <= rd_view_s ^ exp_s;
          end
          if (last_op_s) begin
            state_r   <= ST_DONE;
            bist_busy <= 1'b0;
            bist_done <= 1'b1;
            pass      <= !(err_r || mismatch_s);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          bist_busy <= 1'b0;
          bist_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_march_bist.sv
// Randomized scoreboard bench for regfile_march_bist: a reference array plus a
// table-driven March C- model predict reads and BIST results.
module tb_regfile_march_bist;

  localparam int WIDTH      = 4;
  localparam int DEPTH      = 4;
  localparam int AW         = 2;
  localparam int FAULT_ADDR = 2;
  localparam int ONES       = (1 << WIDTH) - 1;
  localparam int RUN_LEN    = 10 * DEPTH;

  typedef struct {
    bit pass;
    int faddr;
    int syn;
    int busy_len;
  } bist_exp_t;

  logic             clk = 1'b0;
  logic             rst_n, wr_en, bist_start, fault_inj;
  logic [AW-1:0]    wr_addr, rd_addr, fail_addr;
  logic [WIDTH-1:0] d_in, d_out, fail_syndrome;
  logic             bist_busy, bist_done, pass;

  int        checks   = 0;
  int        failures = 0;
  int        ref_mem[DEPTH];
  int        rd_q[$];
  bist_exp_t bist_q[$];
  bit        rd_chk   = 1'b0;
  bit        prev_busy = 1'b0;
  bit        prev_done = 1'b0;
  int        busy_cnt = 0;

  regfile_march_bist #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FAULT_ADDR(FAULT_ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .d_in(d_in),
    .rd_addr(rd_addr), .d_out(d_out), .bist_start(bist_start), .fault_inj(fault_inj),
    .bist_busy(bist_busy), .bist_done(bist_done), .pass(pass),
    .fail_addr(fail_addr), .fail_syndrome(fail_syndrome)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int view(input int word, input int a, input bit inj);
    if (inj && a == FAULT_ADDR) return word & (ONES & ~1);
    return word;
  endfunction

  // March C- as a table of elements; op codes 1=w0 2=w1 3=r0 4=r1, 0=none.
  function automatic void march_model(input bit inj, output bit p, output int fa, output int sy);
    int op_tab[6][2];
    bit down_tab[6];
    int mem[DEPTH];
    bit err;
    int a, v, e_val;
    op_tab   = '{'{1, 0}, '{3, 2}, '{4, 1}, '{3, 2}, '{4, 1}, '{3, 0}};
    down_tab = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    err = 1'b0; fa = 0; sy = 0;
    foreach (mem[i]) mem[i] = 0;
    for (int e = 0; e < 6; e++)
      for (int k = 0; k < DEPTH; k++) begin
        a = down_tab[e] ? DEPTH - 1 - k : k;
        for (int j = 0; j < 2; j++) begin
          case (op_tab[e][j])
            1: mem[a] = 0;
            2: mem[a] = ONES;
            3, 4: begin
              e_val = (op_tab[e][j] == 4) ? ONES : 0;
              v = view(mem[a], a, inj);
              if (v != e_val && !err) begin
                err = 1'b1; fa = a; sy = v ^ e_val;
              end
            end
            default: ;
          endcase
        end
      end
    p = !err;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int a);
    rd_addr = AW'(a);
    rd_q.push_back(view(ref_mem[a], a, fault_inj));
    rd_chk = 1'b1;
    step();
    rd_chk = 1'b0;
  endtask

  task automatic do_write(input int a, input int d, input bit also_read);
    wr_en = 1'b1; wr_addr = AW'(a); d_in = WIDTH'(d);
    if (also_read) begin
      rd_addr = AW'(a);
      rd_q.push_back(view(ref_mem[a], a, fault_inj));
      rd_chk = 1'b1;
    end
    step();
    ref_mem[a] = d;
    wr_en = 1'b0; rd_chk = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) do_read(a);
  endtask

  task automatic run_bist(input bit interfere, input bit midstart, input int abort_at);
    bist_exp_t ex;
    bit p, seen;
    int fa, sy;
    seen = 1'b0;
    march_model(fault_inj, p, fa, sy);
    if (abort_at < 0) begin
      ex.pass = p; ex.faddr = fa; ex.syn = sy; ex.busy_len = RUN_LEN;
      bist_q.push_back(ex);
    end
    bist_start = 1'b1;
    step();
    bist_start = 1'b0;
    if (interfere) begin
      wr_en = 1'b1; wr_addr = AW'(1); d_in = WIDTH'(ONES);
    end
    for (int k = 1; k <= RUN_LEN + 20 && !seen; k++) begin
      bist_start = (midstart && k == 20);
      if (k == abort_at) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; wr_en = 1'b0; bist_start = 1'b0;
        chk("abort_busy", int'(bist_busy), 0);
        chk("abort_done", int'(bist_done), 0);
        chk("abort_pass", int'(pass), 0);
        foreach (ref_mem[i]) ref_mem[i] = 0;
        return;
      end
      step();
      if (bist_done) seen = 1'b1;
    end
    wr_en = 1'b0; bist_start = 1'b0;
    if (!seen) chk("bist_done_timeout", 0, 1);
    foreach (ref_mem[i]) ref_mem[i] = 0;
  endtask

  // Monitor: pops expectations whenever the DUT presents read data or a BIST result.
  always @(negedge clk) begin
    bist_exp_t ex;
    if (rd_chk) begin
      if (rd_q.size() == 0) chk("rd_q_underflow", 1, 0);
      else chk("d_out", int'(d_out), rd_q.pop_front());
    end
    if (bist_busy) begin
      chk("d_out_run_zero", int'(d_out), 0);
      if (!prev_busy) begin
        busy_cnt = 1;
        chk("start_clr_done", int'(bist_done), 0);
        chk("start_clr_pass", int'(pass), 0);
        chk("start_clr_faddr", int'(fail_addr), 0);
        chk("start_clr_syn", int'(fail_syndrome), 0);
      end else begin
        busy_cnt++;
      end
    end
    if (bist_done && !prev_done) begin
      if (bist_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        ex = bist_q.pop_front();
        chk("busy_len", busy_cnt, ex.busy_len);
        chk("pass", int'(pass), int'(ex.pass));
        chk("fail_addr", int'(fail_addr), ex.faddr);
        chk("fail_syndrome", int'(fail_syndrome), ex.syn);
      end
    end
    prev_busy = bist_busy;
    prev_done = bist_done;
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; bist_start = 1'b0; fault_inj = 1'b0;
    wr_addr = '0; rd_addr = '0; d_in = '0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_busy", int'(bist_busy), 0);
    chk("rst_done", int'(bist_done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_faddr", int'(fail_addr), 0);
    chk("rst_syn", int'(fail_syndrome), 0);
    foreach (ref_mem[i]) ref_mem[i] = 0;
    read_all();

    do_write(2, 7, 1'b0);
    do_read(2);
    do_read(1);

    for (int n = 0; n < 40; n++) begin
      fault_inj = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0: do_write($urandom_range(0, DEPTH - 1), $urandom_range(0, ONES), 1'b0);
        1: do_write($urandom_range(0, DEPTH - 1), $urandom_range(0, ONES), 1'b1);
        default: do_read($urandom_range(0, DEPTH - 1));
      endcase
    end

    fault_inj = 1'b0;
    run_bist(1'b0, 1'b0, -1);
    read_all();
    fault_inj = 1'b1;
    run_bist(1'b0, 1'b0, -1);
    read_all();
    fault_inj = 1'b0;
    run_bist(1'b1, 1'b1, -1);
    read_all();

    do_write(3, 9, 1'b0);
    run_bist(1'b0, 1'b0, 15);
    read_all();
    run_bist(1'b0, 1'b0, -1);

    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 4; n++) do_write($urandom_range(0, DEPTH - 1), $urandom_range(0, ONES), 1'b0);
      fault_inj = $urandom_range(0, 1);
      run_bist($urandom_range(0, 1), $urandom_range(0, 1), -1);
      read_all();
    end

    fault_inj = 1'b0;
    for (int n = 0; n < 8; n++) begin
      do_write($urandom_range(0, DEPTH - 1), $urandom_range(0, ONES), $urandom_range(0, 1));
      do_read($urandom_range(0, DEPTH - 1));
    end

    step(); step(); step();
    chk("rd_q_empty", rd_q.size(), 0);
    chk("bist_q_empty", bist_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_march_bist.md
Name: regfile_march_bist

Overview:
- Parametrised successor to the single-register BIST: a DEPTH x WIDTH flop register file with a built-in March C- self-test controller.
- In functional mode it is an ordinary 1W/1R register bank.
- On request it takes over the array, runs March C- and reports pass/fail with first-failure address and syndrome.
- A debug fault-injection input lets benches exercise the fail path.

Parameters:
- WIDTH, 4, data bits per word (1..64).
- DEPTH, 4, number of words (power of two, >=2).
- AW, $clog2(DEPTH), address width (derived; do not override).
- FAULT_ADDR, 0, word whose bit 0 is forced stuck-at-0 while fault_inj=1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- wr_en  in  1  functional write enable.
- wr_addr  in  AW  functional write address.
- d_in  in  WIDTH  functional write data.
- rd_addr  in  AW  functional read address.
- d_out  out  WIDTH  functional read data (combinational from array).
- bist_start  in  1  pulse/level; sampled only in IDLE or DONE.
- fault_inj  in  1  debug; forces stuck-at-0 on bit 0 of FAULT_ADDR.
- bist_busy  out  1  high while test running.
- bist_done  out  1  high in DONE (sticky).
- pass  out  1  valid when bist_done=1.
- fail_addr  out  AW  address of first mismatch.
- fail_syndrome  out  WIDTH  expected XOR read at first mismatch.

Behaviour:
- Reset (rst_n=0 at posedge): array cleared to 0; FSM to IDLE; bist_busy=0, bist_done=0, pass=0, fail_addr=0, fail_syndrome=0. d_out therefore reads 0.
- Reset mid-test aborts immediately, with no partial result retained.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE -> RUN on bist_start=1. Clears pass, fail_*, bist_done that edge.
  - RUN -> DONE after last op.
  - DONE holds until next bist_start or reset.
- March C- sequence, one op per cycle:
  - E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
  - "0"/"1" mean all-zeros / all-ones words.
  - Total RUN length is exactly 10*DEPTH cycles; bist_busy=1 for exactly those cycles.
  - bist_done rises on the edge after the final op.
  - Within an r,w pair: the read op compares in its cycle, and the write to the same address lands at the end of the next cycle.
- Read compare: combinational on the array word (including injection mask) during the read cycle.
  - On the first mismatch, fail_addr/fail_syndrome are captured and an internal error flag is set.
  - Later mismatches never overwrite.
  - The test always runs to completion; there is no early abort.
- pass=1 in DONE iff no mismatch occurred.
- Injection: while fault_inj=1, all reads of word FAULT_ADDR (BIST and functional) see bit 0 = 0. Writes still store the true value.
- During RUN:
  - wr_en is ignored (functional writes dropped, not queued).
  - d_out=0.
  - bist_start is ignored (no restart).
- After DONE, array contents are the March residue (all zeros). Software must reload.
- Functional write and read to the same address in one cycle: d_out shows the old value; the new value appears the next cycle.
- Addresses >= DEPTH cannot occur (DEPTH is a power of two).

Test Plan:
- Functional: reset, write 0x7 to addr 2, read addr 2 next cycle -> d_out=0x7. Read addr 1 -> 0x0.
- Clean BIST (WIDTH=4, DEPTH=4): pulse bist_start -> bist_busy high exactly 40 cycles. bist_done=1 on cycle 41, pass=1, fail_addr=0, fail_syndrome=0. Subsequent read of any addr -> 0x0.
- Injected fault (FAULT_ADDR=2, fault_inj=1): run BIST -> pass=0, fail_addr=2, fail_syndrome=0x1. First detection is in E2 (r1), whose E1 read (r0) would agree.
- Interference: hold wr_en=1, d_in=0xF, wr_addr=1 throughout RUN -> pass=1, addr 1 reads 0x0 after DONE. bist_start pulsed mid-run does not extend busy beyond 40 cycles.
- Reset mid-operation: assert rst_n=0 at RUN cycle 15 -> next cycle bist_busy=0, bist_done=0, pass=0, array all zero. A new start then completes normally with pass=1.
- Re-run: after a failed run, clear fault_inj and pulse bist_start -> the start edge clears pass/fail_*; the new run ends with pass=1, fail_addr=0.
